cp0_except_ctrl: RTL
====================

CP0_EXCEPT_CTRL -- requirements
Module: cp0_except_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- HW_INT_N, 6, hardware interrupt lines (1..6) mapped to Cause.IP[2+HW_INT_N-1:2].
- TIMER_EN, 1, 1 = Count/Compare timer present and ORed into IP[7].
- EXC_VECTOR, 32'hbfc0_0380, redirect target for every non-ERET exception.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ext_int  in  HW_INT_N  level hardware interrupt requests.
- validM  in  1  M-stage holds a real instruction.
- stallM  in  1  M-stage stalled this cycle.
- ri, brk, syscall, overflow, adel_data, ades_data, pc_error, eretM  in  1 each  exception flags of the M instruction.
- is_in_delayslotM  in  1  M instruction is in a delay slot.
- pcM  in  32  M instruction PC.
- alu_outM  in  32  data address.
- mtc0_en  in  1  CP0 write request.
- cp0_waddr, cp0_raddr  in  5 each  CP0 write/read register numbers.
- cp0_wdata  in  32  write data.
- cp0_rdata  out  32  read data.
- except_type  out  32  encoded exception class.
- flush_exception, pc_trap  out  1 each  pipeline flush and PC redirect.
- pc_exception  out  32  redirect target.
- epc_o, status_o, cause_o  out  32 each  current register values.

Function
REQ-003 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other addresses read 0, and writes to them are ignored.
REQ-004 Status write mask: IM[15:8], EXL[1], IE[0]; BEV[22] is read-only 1; Cause write mask: IP[9:8] only; Count, Compare, EPC fully writable; BadVAddr read-only.
REQ-005 Cause.IP[2+k] is registered from ext_int[k] every cycle (one-cycle sampling latency); unused IP bits read 0, except IP[7] when TIMER_EN = 1.
REQ-006 Interrupt pending = IE & ~EXL & |(IM & IP), evaluated on current register values.
REQ-007 The commit qualifier is commit = validM & ~stallM; except_type, flush_exception, pc_trap and pc_exception are combinational and forced to NOEXC/0 when commit = 0.
REQ-008 Priority, highest first: INT, AdEL (pc_error or adel_data), RI, SYS, BP, AdES, OV, ERET, NOEXC; ExcCodes: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
REQ-009 pc_exception = EXC_VECTOR for any exception; it is EPC for ERET, and 0 otherwise.
REQ-010 flush_exception = pc_trap.
REQ-011 On a committed exception (not ERET), at the next clock edge:
- Status.EXL <= 1.
- Cause.ExcCode <= code.
- Cause.BD <= is_in_delayslotM.
- EPC <= is_in_delayslotM ? pcM-4 : pcM.
REQ-012 On committed AdEL/AdES, BadVAddr <= pc_error ? pcM : alu_outM; other exceptions leave BadVAddr unchanged.
REQ-013 On committed ERET, Status.EXL <= 0.
REQ-014 When an exception and mtc0_en occur in the same cycle, the mtc0 write is suppressed entirely.
REQ-015 While EXL = 1, later exceptions still redirect and update Cause, but EPC and BD are not rewritten.
REQ-016 Timer (TIMER_EN = 1):
- Count increments once every two clocks via an internal toggle bit.
- When Count == Compare and Compare != 0, Cause.TI[30] <= 1.
- Any Compare write clears TI.
- IP[7] = TI | (HW_INT_N = 6 ? ext_int[5] : 0).
REQ-017 Count writes take effect next cycle and override the increment in that cycle; the wrap from 32'hffff_ffff to 0 is silent.
REQ-018 cp0_rdata is a combinational read of current register values (no write bypass).

Reset
REQ-019 Asynchronous reset values:
- Status = 32'h0040_0000.
- Cause, EPC, BadVAddr, Count, Compare = 0.
- Timer toggle = 0.
REQ-020 All outputs are derived from these reset values; pc_trap = 0 during reset.
REQ-021 Reset asserted mid-operation discards any pending exception commit and clears TI.

Structure
REQ-022 A shared package cp0_pkg holds:
- CP0 register addresses.
- ExcCode constants.
- EXC_TYPE_* encodings.
- Status and Cause write masks and field bit positions.
REQ-023 Count/Compare/TI logic lives in sub-module cp0_timer, instantiated only when TIMER_EN = 1.

Verification
REQ-024 Set Status = 32'h0000_0401 via mtc0 and raise ext_int[0] -> after 2 cycles (sample plus evaluate) with validM = 1, except_type = INT, pc_exception = 32'hbfc0_0380, and EXL = 1 next cycle.
REQ-025 Assert ri and overflow together with pcM = 32'hbfc0_1000 and is_in_delayslotM = 1 -> ExcCode = 10, EPC = 32'hbfc0_0ffc, BD = 1.
REQ-026 Assert pc_error with pcM = 32'hbfc0_0002 -> AdEL, BadVAddr = 32'hbfc0_0002; then eretM -> pc_exception = EPC and EXL cleared next cycle.
REQ-027 Write Compare = 10 and Count = 0 -> TI set after Count reaches 10 (about 20 cycles); IM[7] = 1 triggers INT; writing Compare clears TI.
REQ-028 Assert syscall with stallM = 1 -> no trap; then deassert stallM -> trap in that cycle; a same-cycle mtc0 to EPC is ignored.
REQ-029 Assert rst asynchronously mid-trap -> Status = 32'h0040_0000 and pc_trap = 0 immediately.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, except_type
// encodings and the writable-field masks of Status and Cause.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
  localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_BEV   = 22;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  function automatic logic [4:0] exc_code(input logic [31:0] exc_type);
    case (exc_type)
      EXC_TYPE_ADEL: return EXCCODE_ADEL;
      EXC_TYPE_ADES: return EXCCODE_ADES;
      EXC_TYPE_SYS:  return EXCCODE_SYS;
      EXC_TYPE_BP:   return EXCCODE_BP;
      EXC_TYPE_RI:   return EXCCODE_RI;
      EXC_TYPE_OV:   return EXCCODE_OV;
      default:       return EXCCODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI latches on a
// non-zero Compare match and is cleared by any Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick    <= 1'b0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (i_count_we)
        r_count <= i_wdata;
      else if (r_tick)
        r_count <= r_count + 32'd1;
      if (i_compare_we) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (r_compare != 32'd0 && r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_except_ctrl.sv
// CP0 register file and M-stage exception arbiter: prioritises exceptions,
// redirects the PC and updates Status/Cause/EPC/BadVAddr on commit.
module cp0_except_ctrl
  import cp0_pkg::*;
#(
  parameter int          HW_INT_N   = 6,
  parameter int          TIMER_EN   = 1,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HW_INT_N-1:0] ext_int,
  input  logic                validM,
  input  logic                stallM,
  input  logic                ri,
  input  logic                brk,
  input  logic                syscall,
  input  logic                overflow,
  input  logic                adel_data,
  input  logic                ades_data,
  input  logic                pc_error,
  input  logic                eretM,
  input  logic                is_in_delayslotM,
  input  logic [31:0]         pcM,
  input  logic [31:0]         alu_outM,
  input  logic                mtc0_en,
  input  logic [4:0]          cp0_waddr,
  input  logic [4:0]          cp0_raddr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  output logic [31:0]         except_type,
  output logic                flush_exception,
  output logic                pc_trap,
  output logic [31:0]         pc_exception,
  output logic [31:0]         epc_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o
);

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_bd;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_hw_ip;

  logic [5:0]  w_ext_pad;
  logic [7:0]  w_ip;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic        w_commit;
  logic        w_int_pending;
  logic        w_trap;
  logic        w_exc;
  logic        w_mtc0;

  // Lines beyond HW_INT_N are tied off so IP[7:2] always has a defined value.
  for (genvar gi = 0; gi < 6; gi++) begin : g_ext
    if (gi < HW_INT_N) begin : g_used
      assign w_ext_pad[gi] = ext_int[gi];
    end else begin : g_unused
      assign w_ext_pad[gi] = 1'b0;
    end
  end

  assign w_mtc0 = mtc0_en & ~w_trap;

  if (TIMER_EN != 0) begin : g_timer
    cp0_timer u_timer (
      .clk          (clk),
      .rst          (rst),
      .i_count_we   (w_mtc0 && cp0_waddr == CP0_COUNT),
      .i_compare_we (w_mtc0 && cp0_waddr == CP0_COMPARE),
      .i_wdata      (cp0_wdata),
      .o_count      (w_count),
      .o_compare    (w_compare),
      .o_ti         (w_ti)
    );
  end else begin : g_no_timer
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
    assign w_ti      = 1'b0;
  end

  assign w_ip     = {w_ti | r_hw_ip[5], r_hw_ip[4:0], r_ip_sw};
  assign status_o = r_status;
  assign cause_o  = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};
  assign epc_o    = r_epc;

  assign w_int_pending = r_status[STATUS_IE] & ~r_status[STATUS_EXL]
                       & (|(r_status[STATUS_IM_LO +: 8] & w_ip));
  // Reset gates the commit so a trap never escapes while rst is high.
  assign w_commit = validM & ~stallM & ~rst;

  always_comb begin
    except_type = EXC_TYPE_NOEXC;
    if (w_commit) begin
      if (w_int_pending)             except_type = EXC_TYPE_INT;
      else if (pc_error | adel_data) except_type = EXC_TYPE_ADEL;
      else if (ri)                   except_type = EXC_TYPE_RI;
      else if (syscall)              except_type = EXC_TYPE_SYS;
      else if (brk)                  except_type = EXC_TYPE_BP;
      else if (ades_data)            except_type = EXC_TYPE_ADES;
      else if (overflow)             except_type = EXC_TYPE_OV;
      else if (eretM)                except_type = EXC_TYPE_ERET;
    end
  end

  assign w_trap          = (except_type != EXC_TYPE_NOEXC);
  assign w_exc           = w_trap & (except_type != EXC_TYPE_ERET);
  assign pc_trap         = w_trap;
  assign flush_exception = w_trap;

  always_comb begin
    pc_exception = 32'd0;
    if (except_type == EXC_TYPE_ERET) pc_exception = r_epc;
    else if (w_exc)                   pc_exception = EXC_VECTOR;
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = r_badvaddr;
      CP0_COUNT:    cp0_rdata = w_count;
      CP0_COMPARE:  cp0_rdata = w_compare;
      CP0_STATUS:   cp0_rdata = status_o;
      CP0_CAUSE:    cp0_rdata = cause_o;
      CP0_EPC:      cp0_rdata = r_epc;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status   <= STATUS_RESET;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
      r_bd       <= 1'b0;
      r_exccode  <= 5'd0;
      r_ip_sw    <= 2'd0;
      r_hw_ip    <= 6'd0;
    end else begin
      r_hw_ip <= w_ext_pad;
      if (w_exc) begin
        r_status[STATUS_EXL] <= 1'b1;
        r_exccode            <= exc_code(except_type);
        // A nested exception keeps the original return point.
        if (!r_status[STATUS_EXL]) begin
          r_bd  <= is_in_delayslotM;
          r_epc <= is_in_delayslotM ? pcM - 32'd4 : pcM;
        end
        if (except_type == EXC_TYPE_ADEL || except_type == EXC_TYPE_ADES)
          r_badvaddr <= pc_error ? pcM : alu_outM;
      end else if (except_type == EXC_TYPE_ERET) begin
        r_status[STATUS_EXL] <= 1'b0;
      end else if (mtc0_en) begin
        case (cp0_waddr)
          CP0_STATUS: r_status <= (r_status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
          CP0_CAUSE:  r_ip_sw  <= cp0_wdata[CAUSE_IP_LO +: 2];
          CP0_EPC:    r_epc    <= cp0_wdata;
          default:    ;
        endcase
      end
    end
  end

endmodule
